// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op codes (funct3), FSM state encoding, default widths and op helpers.
package mdu_pkg;

  localparam int MDU_XLEN  = 32;
  localparam int MDU_CNT_W = 6;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Divide family (DIV/DIVU/REM/REMU) has funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM.
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational two's-complement conditional negation, used both for
// operand magnitude conversion and for final result sign correction.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Negate when requested, otherwise pass through.
  assign res_o = neg_i ? ({W{1'b0}} - val_i) : val_i;

endmodule

// File: rtl/mdu_iter_32.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one operation in flight, start/busy/done handshake.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero finish in one cycle instead of 33.
module mdu_iter_32
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   prod_q, prod_d;     // product, or {remainder, quotient}
  logic                neg_q, neg_d;       // negate final result
  logic                divz_q, divz_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [2*XLEN-1:0]   p_fix;
  logic [XLEN-1:0]     d_src, d_fix;
  logic [XLEN:0]       add_sum, rsh, diff;

  assign sa = a[XLEN-1] & op_signed_a(op);
  assign sb = b[XLEN-1] & op_signed_b(op);

  // Magnitudes of -2^31 are exactly 2^31, which an unsigned XLEN field holds.
  mdu_sign_fix #(.W(XLEN))   u_fix_a (.val_i(a),      .neg_i(sa),    .res_o(mag_a));
  mdu_sign_fix #(.W(XLEN))   u_fix_b (.val_i(b),      .neg_i(sb),    .res_o(mag_b));
  mdu_sign_fix #(.W(2*XLEN)) u_fix_p (.val_i(prod_q), .neg_i(neg_q), .res_o(p_fix));
  mdu_sign_fix #(.W(XLEN))   u_fix_d (.val_i(d_src),  .neg_i(neg_q), .res_o(d_fix));

  assign add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
  assign rsh     = prod_q[2*XLEN-1:XLEN-1];
  assign diff    = rsh - {1'b0, mcand_q};
  assign d_src   = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];

`ifdef MDU_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_res;

  // Detect operations whose result is known without iterating.
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (is_div(op)) begin
      if (b == '0) begin
        early     = 1'b1;
        early_res = op[1] ? a : '1;
      end else if (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
        early     = 1'b1;
        early_res = op[1] ? '0 : a;
      end
    end else if ((a == '0) || (b == '0)) begin
      early     = 1'b1;
      early_res = '0;
    end
  end
`endif

  // Next-state, iteration datapath and result selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d   = op;
          a_d    = a;
          cnt_d  = '0;
          divz_d = (b == '0);
          if (is_div(op)) begin
            mcand_d = mag_b;
            prod_d  = {{XLEN{1'b0}}, mag_a};
            neg_d   = op[1] ? sa : (sa ^ sb);   // remainder follows dividend
          end else begin
            mcand_d = mag_a;
            prod_d  = {{XLEN{1'b0}}, mag_b};
            neg_d   = sa ^ sb;
          end
`ifdef MDU_EARLY_OUT_EN
          if (early) begin
            state_d  = S_DONE;
            result_d = early_res;
          end else
`endif
          begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div(op_q)) begin
          prod_d = diff[XLEN] ? {rsh[XLEN-1:0],  prod_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
          prod_d = prod_q[0] ? {add_sum, prod_q[XLEN-1:1]}
                             : {1'b0, prod_q[2*XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div(op_q)) begin
          if (divz_q) result_d = op_q[1] ? a_q : '1;
          else        result_d = d_fix;
        end else begin
          result_d = (op_q == OP_MUL) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iter_32.sv
// Self-checking bench for mdu_iter_32: directed cases, handshake corner
// cases, asynchronous reset mid-operation and randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_mdu_iter_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  mdu_iter_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin if (y == 0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
      3'b101: begin if (y == 0) return 32'hFFFFFFFF; p = ux / uy; return p[31:0]; end
      3'b110: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
      default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_EARLY_OUT_EN
    if (o[2]) begin
      if (y == 0) return 0;
      if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
    end else if (x == 0 || y == 0) return 0;
`endif
    return 33;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operand inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  // Count edges after the accepting edge until done; optionally poke start mid-run.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int lat, input int poke);
    int n, nb;
    n = 0; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (n == poke) begin start = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom); end
      if (n == poke + 1) start = 1'b0;
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    check({tag, "_done"},  done,   1);
    check({tag, "_lat"},   n,      lat);
    check({tag, "_busy"},  nb,     lat);
    check({tag, "_res"},   result, exp);
  endtask

  task automatic tail(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done,   0);
    check({tag, "_hold"},  result, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] e;
    e = model(o, x, y);
    issue(o, x, y);
    wait_done(tag, e, latency(o, x, y), -1);
    tail(tag, e);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry, e1, e2;

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic and boundary cases.
    run_op("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD);
    check("mul_neg_model", result, 32'hFFFFFFEB);
    run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000);
    check("mulh_min_model", result, 32'h40000000);
    run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mulhu_max_model", result, 32'hFFFFFFFE);
    run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2);
    check("mulhsu_model", result, 32'hFFFFFFFF);
    run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2);
    check("div_neg_model", result, 32'hFFFFFFFD);
    run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2);
    check("rem_neg_model", result, 32'hFFFFFFFF);
    run_op("divu",      3'b101, 32'd100,      32'd7);
    check("divu_model", result, 32'd14);
    run_op("remu",      3'b111, 32'd100,      32'd7);
    check("remu_model", result, 32'd2);
    run_op("divu_z",    3'b101, 32'h1234,     32'd0);
    check("divu_z_model", result, 32'hFFFFFFFF);
    run_op("rem_z",     3'b110, 32'h1234,     32'd0);
    check("rem_z_model", result, 32'h1234);
    run_op("div_z_neg", 3'b100, 32'h80000001, 32'd0);
    run_op("remu_z",    3'b111, 32'hDEADBEEF, 32'd0);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_model", result, 32'h80000000);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF);
    check("rem_ovf_model", result, 32'h0);
    run_op("mul_zero",  3'b001, 32'h0,        32'h12345678);

    // Start while busy is ignored.
    e1 = model(3'b100, 32'd1000, 32'hFFFFFFF9);
    issue(3'b100, 32'd1000, 32'hFFFFFFF9);
    wait_done("ign", e1, 33, 10);
    tail("ign", e1);

    // Start during the DONE cycle is accepted back-to-back.
    e1 = model(3'b011, 32'hCAFEF00D, 32'h0BADBEEF);
    e2 = model(3'b111, 32'hCAFEF00D, 32'd12345);
    issue(3'b011, 32'hCAFEF00D, 32'h0BADBEEF);
    wait_done("b2b1", e1, 33, -1);
    issue(3'b111, 32'hCAFEF00D, 32'd12345);
    wait_done("b2b2", e2, 33, -1);
    tail("b2b2", e2);

    // Asynchronous reset in the middle of a multiply.
    issue(3'b000, 32'h00010001, 32'h00020003);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy",   busy,   0);
    check("arst_done",   done,   0);
    check("arst_result", result, 0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_nodone", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", busy, 0);
    run_op("mul_3x5", 3'b000, 32'd3, 32'd5);
    check("mul_3x5_model", result, 32'd15);

    // Randomized operations with occasional corner operands.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        2: ry = 32'($urandom_range(1, 20));
        3: rx = 32'h80000000;
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
